// File: rtl/flash_loader_pkg.sv
// -----------------------------------------------------------------------------
// flash_loader_pkg
// Shared types and constants for the serial boot loader.
//   - frame_state_e : frame FSM state encoding
//   - rx_state_e    : UART receiver FSM state encoding
//   - SYNC_BYTE_DEFAULT, LEN_ZERO_COUNT : frame constants
//   - csum_add, frame_len : small arithmetic helpers
// Optional feature macro used by the design: FLASH_LOADER_CHECKSUM_EN
// -----------------------------------------------------------------------------
package flash_loader_pkg;

    typedef enum logic [2:0] {
        FS_WAIT_SYNC = 3'd0,
        FS_LEN       = 3'd1,
        FS_DATA      = 3'd2,
        FS_CSUM      = 3'd3,
        FS_FINISH    = 3'd4,
        FS_ERROR     = 3'd5
    } frame_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_BITS  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // A length byte of zero encodes a full 256-byte image.
    localparam logic [8:0] LEN_ZERO_COUNT = 9'd256;

    // Running modulo-256 sum of the data bytes.
    function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] data);
        return sum + data;
    endfunction

    // Translate the length byte into the 9-bit remaining-byte count.
    function automatic logic [8:0] frame_len(input logic [7:0] len_byte);
        return (len_byte == 8'h00) ? LEN_ZERO_COUNT : {1'b0, len_byte};
    endfunction

endpackage

// File: rtl/flash_loader_if.sv
// -----------------------------------------------------------------------------
// flash_loader_if
// Output bundle of the boot loader towards topLevel.
//   flashEn          : one-cycle instruction write strobe
//   flashInstruction : instruction byte, valid while flashEn=1
//   cpuReset         : active-high processor reset
//   loading          : frame in progress
//   loadDone         : sticky, last frame completed OK
//   loadError        : sticky, last frame failed
// modport master : driven by flash_loader
// modport slave  : observed by topLevel / a bench
// -----------------------------------------------------------------------------
interface flash_loader_if;
    logic       flashEn;
    logic [7:0] flashInstruction;
    logic       cpuReset;
    logic       loading;
    logic       loadDone;
    logic       loadError;

    modport master (
        output flashEn, flashInstruction, cpuReset, loading, loadDone, loadError
    );

    modport slave (
        input flashEn, flashInstruction, cpuReset, loading, loadDone, loadError
    );
endinterface

// File: rtl/flash_loader_uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver: 2-flop synchronizer, bit timer and RX FSM
// (IDLE -> START -> BITS -> STOP), LSB first, mid-bit sampling.
// Ports:
//   clk     : clock
//   reset   : asynchronous active-low reset
//   rx      : serial line, idle high, asynchronous to clk
//   rxByte  : last correctly framed byte
//   rxValid : one-cycle pulse, rxByte updated
//   rxErr   : one-cycle pulse, stop bit sampled low
// Parameter CLKS_PER_BIT (>= 4).
// -----------------------------------------------------------------------------
module uart_rx
    import flash_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rxByte,
    output logic       rxValid,
    output logic       rxErr
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [1:0] R_IDLE  = RX_IDLE;
    localparam logic [1:0] R_START = RX_START;
    localparam logic [1:0] R_BITS  = RX_BITS;
    localparam logic [1:0] R_STOP  = RX_STOP;

    logic          rx_meta_r;
    logic          rx_sync_r;
    logic          rx_prev_r;
    logic [1:0]    state_r;
    logic [CW-1:0] cnt_r;
    logic [2:0]    bit_idx_r;
    logic [7:0]    shift_r;
    logic [7:0]    byte_r;
    logic          valid_r;
    logic          err_r;

    // Line synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // Receive FSM with bit timer; a start needs a true high-to-low edge so a
    // line held low after a framing error does not retrigger reception.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= R_IDLE;
            cnt_r     <= {CW{1'b0}};
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
            byte_r    <= 8'h00;
            valid_r   <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            err_r   <= 1'b0;
            case (state_r)
                R_IDLE: begin
                    cnt_r     <= {CW{1'b0}};
                    bit_idx_r <= 3'd0;
                    if (rx_prev_r && !rx_sync_r) begin
                        state_r <= R_START;
                    end
                end
                R_START: begin
                    if (cnt_r == HALF_LAST) begin
                        cnt_r   <= {CW{1'b0}};
                        // Line back high at mid start bit: treat as a glitch.
                        state_r <= rx_sync_r ? R_IDLE : R_BITS;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                R_BITS: begin
                    if (cnt_r == BIT_LAST) begin
                        cnt_r   <= {CW{1'b0}};
                        shift_r <= {rx_sync_r, shift_r[7:1]};
                        if (bit_idx_r == 3'd7) begin
                            state_r <= R_STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                R_STOP: begin
                    if (cnt_r == BIT_LAST) begin
                        cnt_r   <= {CW{1'b0}};
                        state_r <= R_IDLE;
                        if (rx_sync_r) begin
                            byte_r  <= shift_r;
                            valid_r <= 1'b1;
                        end else begin
                            err_r <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                default: begin
                    state_r <= R_IDLE;
                    cnt_r   <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign rxByte  = byte_r;
    assign rxValid = valid_r;
    assign rxErr   = err_r;

endmodule

// File: rtl/flash_loader.sv
// -----------------------------------------------------------------------------
// flash_loader
// Serial boot loader in front of topLevel. Receives a frame
//   SYNC_BYTE, N (0 means 256), N data bytes [, checksum]
// over UART, writes each data byte through flashEn/flashInstruction and
// pulses cpuReset at sync acceptance and at successful frame end.
// Ports:
//   clk   : clock
//   reset : asynchronous active-low reset
//   rx    : UART receive line (idle high)
//   bus   : flash_loader_if.master (flashEn, flashInstruction, cpuReset,
//           loading, loadDone, loadError)
// Parameters: CLKS_PER_BIT, SYNC_BYTE, TIMEOUT_BITS.
// Macro FLASH_LOADER_CHECKSUM_EN: when defined a trailing modulo-256 checksum
// byte is expected and verified; otherwise the frame ends after byte N.
// -----------------------------------------------------------------------------
module flash_loader
    import flash_loader_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 868,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT_BITS = 20
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rx,
    flash_loader_if.master bus
);

    localparam logic [2:0] S_WAIT_SYNC = FS_WAIT_SYNC;
    localparam logic [2:0] S_LEN       = FS_LEN;
    localparam logic [2:0] S_DATA      = FS_DATA;
    localparam logic [2:0] S_FINISH    = FS_FINISH;
    localparam logic [2:0] S_ERROR     = FS_ERROR;
`ifdef FLASH_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CSUM      = FS_CSUM;
`endif

    logic [7:0] rx_byte_s;
    logic       rx_valid_s;
    logic       rx_err_s;
    logic       timeout_hit_s;

    logic [2:0]              state_r;
    logic [8:0]              remaining_r;
    logic [TIMEOUT_BITS-1:0] tmo_r;
    logic                    flash_en_r;
    logic [7:0]              flash_instr_r;
    logic                    cpu_reset_r;
    logic                    loading_r;
    logic                    load_done_r;
    logic                    load_error_r;
`ifdef FLASH_LOADER_CHECKSUM_EN
    logic [7:0]              csum_r;
`endif

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_rx (
        .clk     (clk),
        .reset   (reset),
        .rx      (rx),
        .rxByte  (rx_byte_s),
        .rxValid (rx_valid_s),
        .rxErr   (rx_err_s)
    );

    assign timeout_hit_s = loading_r && (tmo_r == {TIMEOUT_BITS{1'b1}});

    // Inter-byte idle counter: cleared by each received byte, saturates.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_r <= {TIMEOUT_BITS{1'b0}};
        end else if (!loading_r || rx_valid_s) begin
            tmo_r <= {TIMEOUT_BITS{1'b0}};
        end else if (tmo_r != {TIMEOUT_BITS{1'b1}}) begin
            tmo_r <= tmo_r + TIMEOUT_BITS'(1);
        end else begin
            tmo_r <= tmo_r;
        end
    end

    // Frame FSM and registered outputs. A received byte takes priority over
    // a framing error or timeout seen on the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= S_WAIT_SYNC;
            remaining_r   <= 9'd0;
            flash_en_r    <= 1'b0;
            flash_instr_r <= 8'h00;
            cpu_reset_r   <= 1'b1;
            loading_r     <= 1'b0;
            load_done_r   <= 1'b0;
            load_error_r  <= 1'b0;
`ifdef FLASH_LOADER_CHECKSUM_EN
            csum_r        <= 8'h00;
`endif
        end else begin
            flash_en_r  <= 1'b0;
            cpu_reset_r <= 1'b0;
            case (state_r)
                S_WAIT_SYNC: begin
                    if (rx_valid_s && (rx_byte_s == SYNC_BYTE)) begin
                        cpu_reset_r  <= 1'b1;
                        loading_r    <= 1'b1;
                        load_done_r  <= 1'b0;
                        load_error_r <= 1'b0;
                        state_r      <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (rx_valid_s) begin
                        remaining_r <= frame_len(rx_byte_s);
`ifdef FLASH_LOADER_CHECKSUM_EN
                        csum_r      <= 8'h00;
`endif
                        state_r     <= S_DATA;
                    end else if (rx_err_s || timeout_hit_s) begin
                        load_error_r <= 1'b1;
                        loading_r    <= 1'b0;
                        state_r      <= S_ERROR;
                    end
                end
                S_DATA: begin
                    if (rx_valid_s) begin
                        flash_en_r    <= 1'b1;
                        flash_instr_r <= rx_byte_s;
                        remaining_r   <= remaining_r - 9'd1;
`ifdef FLASH_LOADER_CHECKSUM_EN
                        csum_r        <= csum_add(csum_r, rx_byte_s);
                        if (remaining_r == 9'd1) begin
                            state_r <= S_CSUM;
                        end
`else
                        if (remaining_r == 9'd1) begin
                            cpu_reset_r <= 1'b1;
                            load_done_r <= 1'b1;
                            loading_r   <= 1'b0;
                            state_r     <= S_FINISH;
                        end
`endif
                    end else if (rx_err_s || timeout_hit_s) begin
                        load_error_r <= 1'b1;
                        loading_r    <= 1'b0;
                        state_r      <= S_ERROR;
                    end
                end
`ifdef FLASH_LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (rx_valid_s) begin
                        loading_r <= 1'b0;
                        if (rx_byte_s == csum_r) begin
                            cpu_reset_r <= 1'b1;
                            load_done_r <= 1'b1;
                            state_r     <= S_FINISH;
                        end else begin
                            load_error_r <= 1'b1;
                            state_r      <= S_ERROR;
                        end
                    end else if (rx_err_s || timeout_hit_s) begin
                        load_error_r <= 1'b1;
                        loading_r    <= 1'b0;
                        state_r      <= S_ERROR;
                    end
                end
`endif
                // Outputs were set on entry; these states only return home.
                S_FINISH: begin
                    state_r <= S_WAIT_SYNC;
                end
                S_ERROR: begin
                    state_r <= S_WAIT_SYNC;
                end
                default: begin
                    loading_r <= 1'b0;
                    state_r   <= S_WAIT_SYNC;
                end
            endcase
        end
    end

    assign bus.flashEn          = flash_en_r;
    assign bus.flashInstruction = flash_instr_r;
    assign bus.cpuReset         = cpu_reset_r;
    assign bus.loading          = loading_r;
    assign bus.loadDone         = load_done_r;
    assign bus.loadError        = load_error_r;

endmodule

// File: tb/tb_flash_loader.sv
// -----------------------------------------------------------------------------
// tb_flash_loader
// Scoreboard bench for flash_loader (CLKS_PER_BIT=4, TIMEOUT_BITS=8).
// Stimulus pushes expected write strobes / cpuReset pulses into a queue; a
// monitor on the falling edge pops and compares every strobe and pulse.
// Honours FLASH_LOADER_CHECKSUM_EN when the design is built with it.
// -----------------------------------------------------------------------------
module tb_flash_loader;

    localparam int CPB = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic rx    = 1'b1;
    logic mon_en = 1'b0;

    int checks   = 0;
    int failures = 0;

    // Expected events: {1'b1, byte} = write strobe, {1'b0, 8'h00} = cpuReset pulse.
    logic [8:0] exp_q[$];

    flash_loader_if bus();

    flash_loader #(
        .CLKS_PER_BIT(CPB),
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_BITS(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe/pulse must match the head of the queue.
    always @(negedge clk) begin
        if (mon_en && reset) begin
            if (bus.flashEn) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", {23'd0, 1'b1, bus.flashInstruction}, 32'h0);
                end else begin
                    check("strobe", {23'd0, 1'b1, bus.flashInstruction}, {23'd0, exp_q.pop_front()});
                end
            end
            if (bus.cpuReset) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_cpu_reset", 32'h1, 32'h0);
                end else begin
                    check("cpu_reset_pulse", 32'h0, {23'd0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop_ok;
        tick(CPB);
        rx = 1'b1;
        tick(2);
    endtask

    task automatic push_w(input logic [7:0] b);
        exp_q.push_back({1'b1, b});
    endtask

    task automatic push_p();
        exp_q.push_back(9'h000);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            tick(1);
            n++;
        end
        tick(4);
        check(name, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    task automatic check_status(input string name, input logic ld, input logic dn, input logic er);
        check({name, "_loading"}, {31'd0, bus.loading}, {31'd0, ld});
        check({name, "_done"},    {31'd0, bus.loadDone}, {31'd0, dn});
        check({name, "_error"},   {31'd0, bus.loadError}, {31'd0, er});
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_cpu_reset"}, {31'd0, bus.cpuReset}, 32'd1);
        check({name, "_flash_en"},  {31'd0, bus.flashEn}, 32'd0);
        check({name, "_instr"},     {24'd0, bus.flashInstruction}, 32'h00);
        check_status(name, 1'b0, 1'b0, 1'b0);
    endtask

    logic [7:0] sum;

    initial begin
        // Power-up: reset low for 3 cycles.
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check_reset_values("powerup");
        end
        reset = 1'b1;
        tick(1);
        check("powerup_release_cpu_reset", {31'd0, bus.cpuReset}, 32'd0);
        check_status("powerup_release", 1'b0, 1'b0, 1'b0);
        mon_en = 1'b1;
        tick(4);

        // Noise bytes and a one-cycle glitch produce nothing.
        send_byte(8'h3C, 1'b1);
        send_byte(8'h0F, 1'b1);
        rx = 1'b0;
        tick(1);
        rx = 1'b1;
        tick(12);
        wait_drain("noise_drain");
        check_status("noise", 1'b0, 1'b0, 1'b0);

        // Good frame A5 03 11 22 33 [66].
        push_p();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h03, 1'b1);
        check_status("good_mid", 1'b1, 1'b0, 1'b0);
        push_w(8'h11);
        send_byte(8'h11, 1'b1);
        push_w(8'h22);
        send_byte(8'h22, 1'b1);
        push_w(8'h33);
`ifdef FLASH_LOADER_CHECKSUM_EN
        send_byte(8'h33, 1'b1);
        push_p();
        send_byte(8'h66, 1'b1);
`else
        push_p();
        send_byte(8'h33, 1'b1);
`endif
        tick(8);
        wait_drain("good_drain");
        check_status("good_end", 1'b0, 1'b1, 1'b0);
        check("good_instr_hold", {24'd0, bus.flashInstruction}, 32'h33);

`ifdef FLASH_LOADER_CHECKSUM_EN
        // Checksum mismatch A5 02 01 02 04: two writes, no final pulse.
        push_p();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        push_w(8'h01);
        send_byte(8'h01, 1'b1);
        push_w(8'h02);
        send_byte(8'h02, 1'b1);
        send_byte(8'h04, 1'b1);
        tick(8);
        wait_drain("csum_drain");
        check_status("csum_bad", 1'b0, 1'b0, 1'b1);
`endif

        // Framing error on the 2nd data byte.
        push_p();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h03, 1'b1);
        push_w(8'h11);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        tick(8);
        wait_drain("framing_drain");
        check_status("framing", 1'b0, 1'b0, 1'b1);

        // Timeout: line idle after the length byte.
        push_p();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        check_status("timeout_mid", 1'b1, 1'b0, 1'b0);
        tick(300);
        wait_drain("timeout_drain");
        check_status("timeout", 1'b0, 1'b0, 1'b1);

        // Reset after the first data byte.
        push_p();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h03, 1'b1);
        push_w(8'h11);
        send_byte(8'h11, 1'b1);
        tick(4);
        wait_drain("midreset_drain");
        mon_en = 1'b0;
        reset  = 1'b0;
        #1;
        check_reset_values("midreset");
        tick(2);
        reset = 1'b1;
        tick(1);
        check("midreset_release_cpu_reset", {31'd0, bus.cpuReset}, 32'd0);
        mon_en = 1'b1;
        tick(4);

        // N=0 frame: 256 data bytes.
        sum = 8'h00;
        push_p();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        for (int k = 0; k < 256; k++) begin
            logic [7:0] d;
            d = 8'(k) ^ 8'h5A;
            sum = sum + d;
            push_w(d);
`ifndef FLASH_LOADER_CHECKSUM_EN
            if (k == 255) begin
                push_p();
            end
`endif
            send_byte(d, 1'b1);
        end
`ifdef FLASH_LOADER_CHECKSUM_EN
        push_p();
        send_byte(sum, 1'b1);
`endif
        tick(8);
        wait_drain("n0_drain");
        check_status("n0_end", 1'b0, 1'b1, 1'b0);
        check("n0_instr_hold", {24'd0, bus.flashInstruction}, 32'h5A ^ 32'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/flash_loader.md
# flash_loader

Serial boot loader that sits directly upstream of `topLevel`. It receives a framed program image over a UART line, streams it byte-by-byte into instruction memory through the `flashEn`/`flashInstruction` port pair, and sequences the processor's reset around the load. This replaces bench-driven flashing on hardware.

## Interface
- `CLKS_PER_BIT`, 868: clocks per UART bit (100 MHz / 115200); minimum 4.
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `TIMEOUT_BITS`, 20: inter-byte timeout counter width; timeout at 2^TIMEOUT_BITS-1 idle clocks.
- `clk`, in, 1: single clock.
- `reset`, in, 1: asynchronous, active-low.
- `rx`, in, 1: UART receive line; idle high; asynchronous to `clk`.
- `flashEn`, out, 1: one-cycle write strobe to `topLevel`.
- `flashInstruction`, out, 8: instruction byte; valid while `flashEn`=1.
- `cpuReset`, out, 1: active-high reset to `topLevel`.
- `loading`, out, 1: high from sync acceptance to frame end.
- `loadDone`, out, 1: sticky; last frame completed OK.
- `loadError`, out, 1: sticky; last frame failed (framing, timeout, checksum).

## Operation
- `rx` passes a 2-flop synchronizer. The UART RX FSM is IDLE -> START -> BITS(8, LSB first) -> STOP.
- Start: a falling edge is qualified at mid-bit (`CLKS_PER_BIT/2`). If `rx` is high there, the FSM returns to IDLE.
- Sampling: each data bit and the stop bit is sampled at its mid-bit point.
- Stop bit low: framing error, raised as a one-cycle `rxErr` pulse.
- A good stop bit raises a one-cycle `rxValid` pulse with `rxByte`.
- Frame FSM: WAIT_SYNC -> LEN -> DATA -> (CSUM) -> FINISH; ERROR is reachable from LEN/DATA/CSUM.
- WAIT_SYNC:
  - Bytes other than `SYNC_BYTE` are ignored.
  - On `SYNC_BYTE`: `cpuReset` pulses for 1 cycle, `loading`=1, `loadDone`=0, `loadError`=0.
- LEN: the byte is the count N; N=0 means 256. The 9-bit remaining counter is loaded.
- DATA: each byte drives `flashInstruction`=byte and pulses `flashEn` for 1 cycle. The remaining counter decrements and the 8-bit checksum accumulates the byte, modulo 256. When remaining reaches 0, go to CSUM (or FINISH).
- CSUM: the received byte is compared with the accumulated sum. Equal goes to FINISH; unequal goes to ERROR.
- FINISH: `cpuReset` pulses for 1 cycle, `loadDone`=1, `loading`=0, then WAIT_SYNC.
- ERROR (from `rxErr`, timeout, or checksum mismatch): `loadError`=1, `loading`=0, no restart pulse, then WAIT_SYNC.
- Already-written bytes are not rolled back.
- Timeout: the counter clears on every `rxValid` and runs only while `loading`=1. Saturation triggers ERROR.

## Timing
- Reset values while `reset`=0:
  - `flashEn`=0, `flashInstruction`=8'h00.
  - `cpuReset`=1; it deasserts on the first clock edge after `reset` rises.
  - `loading`=0, `loadDone`=0, `loadError`=0.
- `rxValid` occurs 1 cycle after the stop-bit mid-sample.
- `flashEn` asserts on the cycle after `rxValid`. Total latency from stop-bit mid-sample to `flashEn` is 2 cycles.
- `flashInstruction` holds its value until the next data byte.
- Sync `cpuReset` pulse occurs on the cycle after `rxValid` of the sync byte.
- FINISH pulse occurs on the cycle after `rxValid` of the final data byte (or of the checksum byte).
- Strobe spacing: `flashEn` strobes are at least 10·`CLKS_PER_BIT` apart. No backpressure; `topLevel` accepts a write every cycle.
- Simultaneous timeout and `rxValid` on the same cycle: `rxValid` wins.
- `reset` mid-frame: all outputs return to reset values immediately and the FSM returns to WAIT_SYNC.

## Configuration
- `FLASH_LOADER_CHECKSUM_EN` defined:
  - The CSUM state and the checksum accumulator exist.
  - A trailing checksum byte is expected.
  - A mismatch sets `loadError` and suppresses the restart pulse.
- Undefined:
  - No checksum byte is expected and no accumulator is built.
  - The frame goes DATA -> FINISH after the N-th byte.

## Structure
- Shared package `flash_loader_pkg`:
  - frame state enum;
  - UART RX state enum;
  - `SYNC_BYTE` default;
  - the N=0 -> 256 length constant.
- Sub-module `uart_rx`, holding the synchronizer, bit timer and RX FSM. It outputs `rxByte`, `rxValid` and `rxErr`.
- Frame FSM and output registers live in `flash_loader`.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `TIMEOUT_BITS`=8.
- Power-up:
  - Stimulus: `reset` low for 3 cycles, then high.
  - Response: `cpuReset`=1 during reset and 0 one cycle after; all other outputs stay 0.
- Good frame:
  - Stimulus: A5, 03, 11, 22, 33 (plus checksum 66 with `FLASH_LOADER_CHECKSUM_EN`).
  - Response: sync `cpuReset` pulse; `flashEn` strobes with `flashInstruction` 11, 22, 33; final `cpuReset` pulse; `loadDone`=1.
- Checksum mismatch (with `FLASH_LOADER_CHECKSUM_EN`):
  - Stimulus: A5, 02, 01, 02, 04.
  - Response: two strobes; `loadError`=1; no final `cpuReset` pulse.
- Noise and glitches:
  - Stimulus: 3C, 0F before A5, plus a 1-cycle low glitch on idle `rx`.
  - Response: no strobes or pulses until A5 arrives.
- Framing error and timeout:
  - Stimulus: stop bit forced low on the 2nd data byte; separately, the line left idle after the length byte.
  - Response: `loadError`=1 and `loading`=0 in both cases.
- Reset mid-frame and N=0:
  - Stimulus: assert `reset` after the 1st data byte; after release, send A5, 00 and 256 bytes.
  - Response: outputs return to reset values; the second frame produces 256 strobes, then `loadDone`=1.
